// File: rtl/collatz_seq_if.sv
// collatz_seq_if: pin bundle between a controller and the Collatz engine.
//
// Handshake: there is no valid/ready pair. The controller drives `load` and
// `start` as levels, and the engine samples them on every rising clock edge
// while it is not in RUN. `load` has priority over `start`. The controller
// sees that an iteration has finished when `busy` falls and either `done` or
// `err` rises. `sel` may change at any time, and `out` follows it
// combinationally.
//
// Signals:
//   n, load, start, sel       controller -> engine
//   out, busy, done, err      engine -> controller
//   dbg_state                 engine FSM state, for observation only
interface collatz_seq_if #(
  parameter int CNT_W = 8
);
  localparam int SEL_W = (CNT_W > 4) ? $clog2(CNT_W / 4) : 1;

  logic             n;
  logic             load;
  logic             start;
  logic [SEL_W-1:0] sel;
  logic [3:0]       out;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       dbg_state;

  modport master (
    output n, load, start, sel,
    input  out, busy, done, err, dbg_state
  );

  modport slave (
    input  n, load, start, sel,
    output out, busy, done, err, dbg_state
  );
endinterface

// File: rtl/collatz_seq.sv
// collatz_seq: iterative Collatz engine.
//
// A start value is shifted in MSB-first on bus.n while bus.load=1. A level
// on bus.start (with load=0) copies the value into the iteration register.
// The engine then applies one Collatz step per clock and counts the steps
// until the value reaches 1. The step count is read back one nibble at a
// time on bus.out, selected by bus.sel.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    collatz_seq_if.slave: n, load, start, sel in; out, busy, done,
//          err, dbg_state out
module collatz_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  collatz_seq_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] value, value_nxt;
  logic [CNT_W-1:0] steps, steps_nxt;
  logic             busy_q, done_q, err_q;

  // 3*value+1 gets two guard bits so that an overflow past WIDTH can be seen.
  logic [WIDTH+1:0] triple;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    value_nxt = value;
    steps_nxt = steps;
    triple    = {2'b00, value} + {1'b0, value, 1'b0} + (WIDTH+2)'(1);

    case (state)
      S_RUN: begin
        if (value == WIDTH'(1)) begin
          state_nxt = S_DONE;
        end else if (steps == {CNT_W{1'b1}}) begin
          state_nxt = S_ERR;
        end else if (!value[0]) begin
          value_nxt = value >> 1;
          steps_nxt = steps + CNT_W'(1);
        end else if (triple[WIDTH+1:WIDTH] != 2'b00) begin
          // 3n+1 does not fit: stop, and leave value/steps as they were.
          state_nxt = S_ERR;
        end else begin
          value_nxt = triple[WIDTH-1:0];
          steps_nxt = steps + CNT_W'(1);
        end
      end
      default: begin
        if (bus.load) begin
          shreg_nxt = {shreg[WIDTH-2:0], bus.n};
          if (state != S_IDLE) begin
            // Starting a reload clears the result of the previous run.
            state_nxt = S_IDLE;
            steps_nxt = '0;
          end
        end else if (bus.start) begin
          // shreg is kept, so a repeated start re-runs the same value.
          value_nxt = shreg;
          steps_nxt = '0;
          state_nxt = (shreg != '0) ? S_RUN : S_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      shreg  <= '0;
      value  <= '0;
      steps  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      value  <= value_nxt;
      steps  <= steps_nxt;
      // The flags are registered from the next state, so they change on
      // the same edge as state.
      busy_q <= (state_nxt == S_RUN);
      done_q <= (state_nxt == S_DONE);
      err_q  <= (state_nxt == S_ERR);
    end
  end

  // Nibble select. steps is zero-padded to 16 bits, so out-of-range select
  // values read as zero.
  logic [15:0] steps_ext;
  logic [1:0]  sel2;

  always_comb begin
    steps_ext              = '0;
    steps_ext[CNT_W-1:0]   = steps;
    sel2                   = 2'(bus.sel);
  end

  assign bus.out       = steps_ext[{sel2, 2'b00} +: 4];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state;
endmodule
